// File: rtl/rs_rtype_scheduler.sv
// R-type reservation station scheduler: holds issued R-type instructions,
// captures missing operands from the CDB, and dispatches the oldest ready
// entry to the R-type ALU through a registered valid/ready port.
module rs_rtype_scheduler #(
  parameter int unsigned RS_ENTRIES = 3,
  parameter int unsigned TAG_W      = 7,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned OP_W       = 6,
  parameter int unsigned IDX_W      = 11
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  alloc_valid,
  output logic                                  alloc_ready,
  input  logic [OP_W-1:0]                       alloc_op,
  input  logic [TAG_W-1:0]                      alloc_dest_tag,
  input  logic [IDX_W-1:0]                      alloc_index,
  input  logic                                  alloc_src1_rdy,
  input  logic                                  alloc_src2_rdy,
  input  logic [TAG_W-1:0]                      alloc_src1_tag,
  input  logic [TAG_W-1:0]                      alloc_src2_tag,
  input  logic [DATA_W-1:0]                     alloc_src1_value,
  input  logic [DATA_W-1:0]                     alloc_src2_value,
  input  logic                                  cdb_valid,
  input  logic [TAG_W-1:0]                      cdb_tag,
  input  logic [DATA_W-1:0]                     cdb_value,
  output logic                                  disp_valid,
  input  logic                                  disp_ready,
  output logic [OP_W-1:0]                       disp_op,
  output logic [TAG_W-1:0]                      disp_dest_tag,
  output logic [IDX_W-1:0]                      disp_index,
  output logic [DATA_W-1:0]                     disp_src1,
  output logic [DATA_W-1:0]                     disp_src2,
  output logic [$clog2(RS_ENTRIES+1)-1:0]       free_count
);

  localparam int unsigned CNT_W = $clog2(RS_ENTRIES + 1);
  localparam int unsigned SEL_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

  // Entry state
  logic [RS_ENTRIES-1:0] busy_q,   busy_d;
  logic [RS_ENTRIES-1:0] s1_rdy_q, s1_rdy_d;
  logic [RS_ENTRIES-1:0] s2_rdy_q, s2_rdy_d;
  logic [OP_W-1:0]       op_q     [RS_ENTRIES];
  logic [OP_W-1:0]       op_d     [RS_ENTRIES];
  logic [TAG_W-1:0]      dest_q   [RS_ENTRIES];
  logic [TAG_W-1:0]      dest_d   [RS_ENTRIES];
  logic [IDX_W-1:0]      idx_q    [RS_ENTRIES];
  logic [IDX_W-1:0]      idx_d    [RS_ENTRIES];
  logic [TAG_W-1:0]      s1_tag_q [RS_ENTRIES];
  logic [TAG_W-1:0]      s1_tag_d [RS_ENTRIES];
  logic [TAG_W-1:0]      s2_tag_q [RS_ENTRIES];
  logic [TAG_W-1:0]      s2_tag_d [RS_ENTRIES];
  logic [DATA_W-1:0]     s1_val_q [RS_ENTRIES];
  logic [DATA_W-1:0]     s1_val_d [RS_ENTRIES];
  logic [DATA_W-1:0]     s2_val_q [RS_ENTRIES];
  logic [DATA_W-1:0]     s2_val_d [RS_ENTRIES];

  // Dispatch register and free counter
  logic              disp_valid_q, disp_valid_d;
  logic [OP_W-1:0]   disp_op_q,    disp_op_d;
  logic [TAG_W-1:0]  disp_dest_q,  disp_dest_d;
  logic [IDX_W-1:0]  disp_idx_q,   disp_idx_d;
  logic [DATA_W-1:0] disp_s1_q,    disp_s1_d;
  logic [DATA_W-1:0] disp_s2_q,    disp_s2_d;
  logic [CNT_W-1:0]  free_cnt_q,   free_cnt_d;

  // Select / allocate helpers
  logic [RS_ENTRIES-1:0] cand;
  logic                  win_valid;
  logic [SEL_W-1:0]      win_sel;
  logic                  have_free;
  logic [SEL_W-1:0]      alloc_sel;
  logic                  alloc_fire;
  logic                  disp_take;
  logic                  s1_cap;
  logic                  s2_cap;

  // Circular age compare: a is older than b when (a - b) has its MSB set.
  function automatic logic is_older(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    logic [IDX_W-1:0] diff;
    diff = a - b;
    return diff[IDX_W-1];
  endfunction

  assign alloc_ready = (free_cnt_q != '0);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign disp_take   = !disp_valid_q || disp_ready;

  // Oldest ready entry; strict compare keeps the lower slot on equal index
  always_comb begin
    cand      = busy_q & s1_rdy_q & s2_rdy_q;
    win_valid = 1'b0;
    win_sel   = '0;
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      if (cand[i] && (!win_valid || is_older(idx_q[i], idx_q[win_sel]))) begin
        win_valid = 1'b1;
        win_sel   = SEL_W'(i);
      end
    end
  end

  // Lowest-numbered free slot, from registered busy bits only
  always_comb begin
    have_free = 1'b0;
    alloc_sel = '0;
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      if (!busy_q[i] && !have_free) begin
        have_free = 1'b1;
        alloc_sel = SEL_W'(i);
      end
    end
  end

  // Next-state: wakeup, dispatch load, allocation, flush
  always_comb begin
    busy_d       = busy_q;
    s1_rdy_d     = s1_rdy_q;
    s2_rdy_d     = s2_rdy_q;
    op_d         = op_q;
    dest_d       = dest_q;
    idx_d        = idx_q;
    s1_tag_d     = s1_tag_q;
    s2_tag_d     = s2_tag_q;
    s1_val_d     = s1_val_q;
    s2_val_d     = s2_val_q;
    disp_valid_d = disp_valid_q;
    disp_op_d    = disp_op_q;
    disp_dest_d  = disp_dest_q;
    disp_idx_d   = disp_idx_q;
    disp_s1_d    = disp_s1_q;
    disp_s2_d    = disp_s2_q;
    free_cnt_d   = '0;
    s1_cap       = 1'b0;
    s2_cap       = 1'b0;

    if (flush) begin
      busy_d       = '0;
      disp_valid_d = 1'b0;
    end else begin
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
        if (busy_q[i] && cdb_valid) begin
          if (!s1_rdy_q[i] && (s1_tag_q[i] == cdb_tag)) begin
            s1_rdy_d[i] = 1'b1;
            s1_val_d[i] = cdb_value;
          end
          if (!s2_rdy_q[i] && (s2_tag_q[i] == cdb_tag)) begin
            s2_rdy_d[i] = 1'b1;
            s2_val_d[i] = cdb_value;
          end
        end
      end

      if (disp_take) begin
        disp_valid_d = win_valid;
        if (win_valid) begin
          disp_op_d       = op_q[win_sel];
          disp_dest_d     = dest_q[win_sel];
          disp_idx_d      = idx_q[win_sel];
          disp_s1_d       = s1_val_q[win_sel];
          disp_s2_d       = s2_val_q[win_sel];
          busy_d[win_sel] = 1'b0;
        end
      end

      if (alloc_fire) begin
        s1_cap              = !alloc_src1_rdy && cdb_valid && (alloc_src1_tag == cdb_tag);
        s2_cap              = !alloc_src2_rdy && cdb_valid && (alloc_src2_tag == cdb_tag);
        busy_d[alloc_sel]   = 1'b1;
        op_d[alloc_sel]     = alloc_op;
        dest_d[alloc_sel]   = alloc_dest_tag;
        idx_d[alloc_sel]    = alloc_index;
        s1_tag_d[alloc_sel] = alloc_src1_tag;
        s2_tag_d[alloc_sel] = alloc_src2_tag;
        s1_rdy_d[alloc_sel] = alloc_src1_rdy || s1_cap;
        s2_rdy_d[alloc_sel] = alloc_src2_rdy || s2_cap;
        s1_val_d[alloc_sel] = s1_cap ? cdb_value : alloc_src1_value;
        s2_val_d[alloc_sel] = s2_cap ? cdb_value : alloc_src2_value;
      end
    end

    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      if (!busy_d[i]) begin
        free_cnt_d = free_cnt_d + CNT_W'(1);
      end
    end
  end

  // Control state and dispatch register, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q       <= '0;
      disp_valid_q <= 1'b0;
      disp_op_q    <= '0;
      disp_dest_q  <= '0;
      disp_idx_q   <= '0;
      disp_s1_q    <= '0;
      disp_s2_q    <= '0;
      free_cnt_q   <= CNT_W'(RS_ENTRIES);
    end else begin
      busy_q       <= busy_d;
      disp_valid_q <= disp_valid_d;
      disp_op_q    <= disp_op_d;
      disp_dest_q  <= disp_dest_d;
      disp_idx_q   <= disp_idx_d;
      disp_s1_q    <= disp_s1_d;
      disp_s2_q    <= disp_s2_d;
      free_cnt_q   <= free_cnt_d;
    end
  end

  // Entry payload; only meaningful while the busy bit is set
  always_ff @(posedge clock) begin
    s1_rdy_q <= s1_rdy_d;
    s2_rdy_q <= s2_rdy_d;
    op_q     <= op_d;
    dest_q   <= dest_d;
    idx_q    <= idx_d;
    s1_tag_q <= s1_tag_d;
    s2_tag_q <= s2_tag_d;
    s1_val_q <= s1_val_d;
    s2_val_q <= s2_val_d;
  end

  assign disp_valid    = disp_valid_q;
  assign disp_op       = disp_op_q;
  assign disp_dest_tag = disp_dest_q;
  assign disp_index    = disp_idx_q;
  assign disp_src1     = disp_s1_q;
  assign disp_src2     = disp_s2_q;
  assign free_count    = free_cnt_q;

endmodule

// File: tb/tb_rs_rtype_scheduler.sv
// Testbench for rs_rtype_scheduler: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the station.
module tb_rs_rtype_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [5:0]  alloc_op = '0;
  logic [6:0]  alloc_dest_tag = '0;
  logic [10:0] alloc_index = '0;
  logic        alloc_src1_rdy = 1'b0;
  logic        alloc_src2_rdy = 1'b0;
  logic [6:0]  alloc_src1_tag = '0;
  logic [6:0]  alloc_src2_tag = '0;
  logic [31:0] alloc_src1_value = '0;
  logic [31:0] alloc_src2_value = '0;
  logic        cdb_valid = 1'b0;
  logic [6:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic        disp_valid;
  logic        disp_ready = 1'b1;
  logic [5:0]  disp_op;
  logic [6:0]  disp_dest_tag;
  logic [10:0] disp_index;
  logic [31:0] disp_src1;
  logic [31:0] disp_src2;
  logic [1:0]  free_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rs_rtype_scheduler dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_dest_tag(alloc_dest_tag), .alloc_index(alloc_index),
    .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
    .alloc_src1_value(alloc_src1_value), .alloc_src2_value(alloc_src2_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_dest_tag(disp_dest_tag), .disp_index(disp_index),
    .disp_src1(disp_src1), .disp_src2(disp_src2), .free_count(free_count)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        busy;
    bit [5:0]  op;
    bit [6:0]  dest;
    int        idx;
    bit        r1, r2;
    bit [6:0]  t1, t2;
    bit [31:0] v1, v2;
  } ent_t;

  ent_t      ms [3];
  bit        e_dv;
  bit [87:0] e_fields;

  function automatic bit older(int a, int b);
    return ((a - b + 2048) % 2048) >= 1024;
  endfunction

  function automatic int m_free();
    int n = 0;
    foreach (ms[i]) if (!ms[i].busy) n++;
    return n;
  endfunction

  task automatic model_edge();
    ent_t nxt [3];
    int   win, slot, nfree;
    if (reset) begin
      foreach (ms[i]) ms[i].busy = 0;
      e_dv = 0;
      e_fields = '0;
      return;
    end
    if (flush) begin
      foreach (ms[i]) ms[i].busy = 0;
      e_dv = 0;
      return;
    end
    nfree = m_free();
    win = -1;
    foreach (ms[i])
      if (ms[i].busy && ms[i].r1 && ms[i].r2 && (win < 0 || older(ms[i].idx, ms[win].idx))) win = i;
    slot = -1;
    foreach (ms[i]) if (!ms[i].busy && slot < 0) slot = i;
    nxt = ms;
    foreach (ms[i]) begin
      if (ms[i].busy && cdb_valid && !ms[i].r1 && ms[i].t1 == cdb_tag) begin nxt[i].r1 = 1; nxt[i].v1 = cdb_value; end
      if (ms[i].busy && cdb_valid && !ms[i].r2 && ms[i].t2 == cdb_tag) begin nxt[i].r2 = 1; nxt[i].v2 = cdb_value; end
    end
    if (!e_dv || disp_ready) begin
      if (win >= 0) begin
        e_dv = 1;
        e_fields = {ms[win].op, ms[win].dest, 11'(ms[win].idx), ms[win].v1, ms[win].v2};
        nxt[win].busy = 0;
      end else begin
        e_dv = 0;
      end
    end
    if (alloc_valid && nfree > 0) begin
      nxt[slot].busy = 1;
      nxt[slot].op   = alloc_op;
      nxt[slot].dest = alloc_dest_tag;
      nxt[slot].idx  = int'(alloc_index);
      nxt[slot].t1   = alloc_src1_tag;
      nxt[slot].t2   = alloc_src2_tag;
      nxt[slot].r1   = alloc_src1_rdy;
      nxt[slot].r2   = alloc_src2_rdy;
      nxt[slot].v1   = alloc_src1_value;
      nxt[slot].v2   = alloc_src2_value;
      if (!alloc_src1_rdy && cdb_valid && alloc_src1_tag == cdb_tag) begin nxt[slot].r1 = 1; nxt[slot].v1 = cdb_value; end
      if (!alloc_src2_rdy && cdb_valid && alloc_src2_tag == cdb_tag) begin nxt[slot].r2 = 1; nxt[slot].v2 = cdb_value; end
    end
    ms = nxt;
  endtask

  // Advance one clock: DUT and model update on the same edge, sample 1ns later
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_alloc(input bit v, input bit [5:0] op, input bit [6:0] dest, input bit [10:0] idx,
                           input bit r1, input bit [6:0] t1, input bit [31:0] v1,
                           input bit r2, input bit [6:0] t2, input bit [31:0] v2);
    alloc_valid = v; alloc_op = op; alloc_dest_tag = dest; alloc_index = idx;
    alloc_src1_rdy = r1; alloc_src1_tag = t1; alloc_src1_value = v1;
    alloc_src2_rdy = r2; alloc_src2_tag = t2; alloc_src2_value = v2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid got=%0b exp=0", disp_valid); end
    checks++; if (free_count !== 2'd3) begin errors++; $display("FAIL reset_free_count got=%0d exp=3", free_count); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got=%0b exp=1", alloc_ready); end
    checks++; if ({disp_op, disp_dest_tag, disp_index, disp_src1, disp_src2} !== 88'h0) begin
      errors++; $display("FAIL reset_disp_fields got=%h exp=0", {disp_op, disp_dest_tag, disp_index, disp_src1, disp_src2}); end
  endtask

  task automatic test_basic_latency();
    disp_ready = 1;
    set_alloc(1, 6'h01, 7'd5, 11'd1, 1, 7'd0, 32'd10, 1, 7'd0, 32'd20);
    tick(); alloc_valid = 0;
    checks++; if (free_count !== 2'd2) begin errors++; $display("FAIL basic_free_after_alloc got=%0d exp=2", free_count); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%0b exp=0", disp_valid); end
    tick();
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", disp_valid); end
    checks++; if ({disp_op, disp_dest_tag, disp_src1, disp_src2} !== {6'h01, 7'd5, 32'd10, 32'd20}) begin
      errors++; $display("FAIL basic_fields got=%h exp=%h", {disp_op, disp_dest_tag, disp_src1, disp_src2}, {6'h01, 7'd5, 32'd10, 32'd20}); end
    checks++; if (free_count !== 2'd3) begin errors++; $display("FAIL basic_free_after_load got=%0d exp=3", free_count); end
    tick();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL basic_drop_valid got=%0b exp=0", disp_valid); end
  endtask

  task automatic test_full_station();
    for (int i = 0; i < 3; i++) begin
      set_alloc(1, 6'(2 + i), 7'(1 + i), 11'(10 + i), 0, 7'd9, 32'd0, 1, 7'd0, 32'(100 + i));
      tick();
    end
    checks++; if (free_count !== 2'd0) begin errors++; $display("FAIL full_free_count got=%0d exp=0", free_count); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready got=%0b exp=0", alloc_ready); end
    set_alloc(1, 6'h3f, 7'd60, 11'd50, 1, 7'd0, 32'd1, 1, 7'd0, 32'd2);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL full_ignored_valid cyc=%0d got=%0b exp=0", c, disp_valid); end
      checks++; if (free_count !== 2'd0) begin errors++; $display("FAIL full_ignored_free cyc=%0d got=%0d exp=0", c, free_count); end
    end
    alloc_valid = 0;
  endtask

  task automatic test_wakeup();
    cdb_valid = 1; cdb_tag = 7'd9; cdb_value = 32'hDEAD;
    tick(); cdb_valid = 0;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL wake_no_bypass got=%0b exp=0", disp_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({disp_valid, disp_index, disp_src1, disp_src2} !== {1'b1, 11'(10 + i), 32'hDEAD, 32'(100 + i)}) begin
        errors++; $display("FAIL wake_dispatch_%0d got=%h exp=%h", i, {disp_valid, disp_index, disp_src1, disp_src2},
                           {1'b1, 11'(10 + i), 32'hDEAD, 32'(100 + i)}); end
    end
    tick();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL wake_drain_valid got=%0b exp=0", disp_valid); end
    checks++; if (free_count !== 2'd3) begin errors++; $display("FAIL wake_drain_free got=%0d exp=3", free_count); end
  endtask

  task automatic test_same_cycle_and_wrap();
    set_alloc(1, 6'h05, 7'd6, 11'd20, 1, 7'd0, 32'd3, 0, 7'd12, 32'd99);
    cdb_valid = 1; cdb_tag = 7'd12; cdb_value = 32'd7;
    tick(); alloc_valid = 0; cdb_valid = 0;
    tick();
    checks++; if ({disp_valid, disp_src1, disp_src2} !== {1'b1, 32'd3, 32'd7}) begin
      errors++; $display("FAIL capture_src2 got=%h exp=%h", {disp_valid, disp_src1, disp_src2}, {1'b1, 32'd3, 32'd7}); end
    tick();
    set_alloc(1, 6'h06, 7'd40, 11'd1, 0, 7'd33, 32'd0, 1, 7'd0, 32'd1);
    tick();
    set_alloc(1, 6'h07, 7'd41, 11'd2047, 0, 7'd33, 32'd0, 1, 7'd0, 32'd2);
    tick(); alloc_valid = 0;
    cdb_valid = 1; cdb_tag = 7'd33; cdb_value = 32'd55;
    tick(); cdb_valid = 0;
    tick();
    checks++; if ({disp_valid, disp_index, disp_dest_tag} !== {1'b1, 11'd2047, 7'd41}) begin
      errors++; $display("FAIL wrap_first got=%h exp=%h", {disp_valid, disp_index, disp_dest_tag}, {1'b1, 11'd2047, 7'd41}); end
    tick();
    checks++; if ({disp_valid, disp_index, disp_src1} !== {1'b1, 11'd1, 32'd55}) begin
      errors++; $display("FAIL wrap_second got=%h exp=%h", {disp_valid, disp_index, disp_src1}, {1'b1, 11'd1, 32'd55}); end
    tick();
  endtask

  task automatic test_backpressure();
    bit [87:0] held;
    disp_ready = 0;
    set_alloc(1, 6'h0a, 7'd7, 11'd100, 1, 7'd0, 32'hA1, 1, 7'd0, 32'hA2);
    tick();
    set_alloc(1, 6'h0b, 7'd8, 11'd101, 1, 7'd0, 32'hB1, 1, 7'd0, 32'hB2);
    tick(); alloc_valid = 0;
    held = {6'h0a, 7'd7, 11'd100, 32'hA1, 32'hA2};
    for (int c = 0; c < 5; c++) begin
      checks++; if ({disp_valid, disp_op, disp_dest_tag, disp_index, disp_src1, disp_src2} !== {1'b1, held}) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, {disp_valid, disp_op, disp_dest_tag, disp_index, disp_src1, disp_src2}, {1'b1, held}); end
      checks++; if (free_count !== 2'd2) begin errors++; $display("FAIL bp_free cyc=%0d got=%0d exp=2", c, free_count); end
      tick();
    end
    disp_ready = 1;
    tick();
    checks++; if ({disp_valid, disp_index, disp_dest_tag} !== {1'b1, 11'd101, 7'd8}) begin
      errors++; $display("FAIL bp_next got=%h exp=%h", {disp_valid, disp_index, disp_dest_tag}, {1'b1, 11'd101, 7'd8}); end
    checks++; if (free_count !== 2'd3) begin errors++; $display("FAIL bp_release_free got=%0d exp=3", free_count); end
    tick();
  endtask

  task automatic test_flush_mid(input bit use_reset);
    disp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_alloc(1, 6'(i), 7'(20 + i), 11'(200 + i), 1, 7'd0, 32'(i), 1, 7'd0, 32'(i));
      tick();
    end
    checks++; if ({disp_valid, free_count} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL clr%0b_pre got=%b exp=%b", use_reset, {disp_valid, free_count}, {1'b1, 2'd1}); end
    set_alloc(1, 6'h11, 7'd30, 11'd300, 1, 7'd0, 32'd5, 1, 7'd0, 32'd6);
    disp_ready = 1;
    if (use_reset) reset = 1; else flush = 1;
    tick();
    reset = 0; flush = 0; alloc_valid = 0;
    checks++; if ({disp_valid, free_count, alloc_ready} !== {1'b0, 2'd3, 1'b1}) begin
      errors++; $display("FAIL clr%0b_post got=%b exp=%b", use_reset, {disp_valid, free_count, alloc_ready}, {1'b0, 2'd3, 1'b1}); end
    if (use_reset) begin
      checks++; if (disp_index !== 11'd0) begin errors++; $display("FAIL clr1_fields got=%0d exp=0", disp_index); end
    end
    tick();
    checks++; if ({disp_valid, free_count} !== {1'b0, 2'd3}) begin
      errors++; $display("FAIL clr%0b_alloc_lost got=%b exp=%b", use_reset, {disp_valid, free_count}, {1'b0, 2'd3}); end
  endtask

  task automatic test_random();
    int idx_ctr = 2030;
    reset = 1; tick(); reset = 0;
    for (int c = 0; c < 800; c++) begin
      set_alloc(($urandom_range(0, 9) < 6), 6'($urandom), 7'($urandom), 11'(idx_ctr),
                $urandom_range(0, 1), 7'($urandom_range(0, 5)), $urandom,
                $urandom_range(0, 1), 7'($urandom_range(0, 5)), $urandom);
      idx_ctr = (idx_ctr + 1) % 2048;
      cdb_valid  = $urandom_range(0, 1);
      cdb_tag    = 7'($urandom_range(0, 5));
      cdb_value  = $urandom;
      disp_ready = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 39) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
      checks++; if (disp_valid !== e_dv) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", c, disp_valid, e_dv); end
      checks++; if (free_count !== 2'(m_free())) begin errors++; $display("FAIL rnd_free cyc=%0d got=%0d exp=%0d", c, free_count, m_free()); end
      checks++; if (alloc_ready !== (m_free() != 0)) begin errors++; $display("FAIL rnd_alloc_ready cyc=%0d got=%0b exp=%0b", c, alloc_ready, m_free() != 0); end
      if (e_dv) begin
        checks++; if ({disp_op, disp_dest_tag, disp_index, disp_src1, disp_src2} !== e_fields) begin
          errors++; $display("FAIL rnd_fields cyc=%0d got=%h exp=%h", c, {disp_op, disp_dest_tag, disp_index, disp_src1, disp_src2}, e_fields); end
      end
    end
    alloc_valid = 0; cdb_valid = 0; flush = 0; reset = 0; disp_ready = 1;
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_full_station();
    test_wakeup();
    test_same_cycle_and_wrap();
    test_backpressure();
    test_flush_mid(1'b0);
    test_flush_mid(1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
